// File: rtl/alu_share_arb.sv
// Two-requester arbiter in front of one shared 32-bit ALU with a single-entry
// registered result stage; round-robin or strict-priority grant.
module alu_share_arb #(
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [3:0]  req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [3:0]  req1_op,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_result,
  output logic        rsp_zero,
  output logic        rsp_illegal
);

  typedef enum logic [0:0] {StEmpty, StFull} state_e;

  state_e      state;
  logic        last_grant;
  logic        grant0, grant1, slot_free, accept;
  logic [31:0] op_a, op_b, alu_res;
  logic [3:0]  op;
  logic [4:0]  shamt;
  logic        alu_ill;

  assign rsp_valid = (state == StFull);
  assign slot_free = !rsp_valid || rsp_ready;

  // last_grant == 1 means requester 1 won last, so requester 0 wins next tie.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (req0_valid && req1_valid) begin
      if (FIXED_PRIO != 0 || last_grant) grant0 = 1'b1;
      else                                grant1 = 1'b1;
    end else begin
      grant0 = req0_valid;
      grant1 = req1_valid;
    end
  end

  assign req0_ready = grant0 && slot_free && !reset;
  assign req1_ready = grant1 && slot_free && !reset;
  assign accept     = req0_ready || req1_ready;

  assign op_a  = grant1 ? req1_a  : req0_a;
  assign op_b  = grant1 ? req1_b  : req0_b;
  assign op    = grant1 ? req1_op : req0_op;
  assign shamt = op_b[4:0];

  always_comb begin
    alu_res = 32'h0;
    alu_ill = 1'b0;
    unique case (op)
      4'b0000: alu_res = op_a + op_b;
      4'b0001: alu_res = op_a - op_b;
      4'b0100: alu_res = op_a & op_b;
      4'b0101: alu_res = op_a | op_b;
      4'b0110: alu_res = op_a ^ op_b;
      4'b0111: alu_res = op_a;
      4'b1000: alu_res = op_a << shamt;
      4'b1010: alu_res = op_a >> shamt;
      4'b1011: alu_res = $unsigned($signed(op_a) >>> shamt);
      4'b1100: alu_res = {31'h0, $signed(op_a) < $signed(op_b)};
      4'b1101: alu_res = {31'h0, op_a < op_b};
      4'b1111: alu_res = op_b;
      default: alu_ill = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= StEmpty;
      last_grant  <= 1'b1;
      rsp_id      <= 1'b0;
      rsp_result  <= 32'h0;
      rsp_zero    <= 1'b0;
      rsp_illegal <= 1'b0;
    end else begin
      if (accept) begin
        last_grant  <= grant1;
        rsp_id      <= grant1;
        rsp_result  <= alu_res;
        rsp_zero    <= (alu_res == 32'h0);
        rsp_illegal <= alu_ill;
      end
      case (state)
        StEmpty: if (accept) state <= StFull;
        StFull:  if (!accept && rsp_ready) state <= StEmpty;
        default: state <= StEmpty;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb: opcode table, arbitration, backpressure,
// drain, reset-while-full and strict-priority behaviour.
module tb_alu_share_arb;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid, rsp_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_op, req1_op;
  logic        req0_ready, req1_ready, rsp_valid, rsp_id, rsp_zero, rsp_illegal;
  logic [31:0] rsp_result;
  logic        fp_req0_ready, fp_req1_ready, fp_rsp_valid, fp_rsp_id, fp_rsp_zero;
  logic        fp_rsp_illegal;
  logic [31:0] fp_rsp_result;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_share_arb #(.FIXED_PRIO(0)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_op(req1_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_zero(rsp_zero), .rsp_illegal(rsp_illegal)
  );

  alu_share_arb #(.FIXED_PRIO(1)) dut_fp (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(fp_req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(fp_req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_op(req1_op),
    .rsp_valid(fp_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(fp_rsp_id),
    .rsp_result(fp_rsp_result), .rsp_zero(fp_rsp_zero), .rsp_illegal(fp_rsp_illegal)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        zero;
    logic        ill;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req0(input logic v, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b);
    req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
  endtask

  task automatic set_req1(input logic v, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b);
    req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
  endtask

  task automatic chk_rsp(input string name, input logic v, input logic id,
                         input logic [31:0] res, input logic z, input logic ill);
    chk({name, ".valid"},   rsp_valid,   v);
    chk({name, ".id"},      rsp_id,      id);
    chk({name, ".result"},  rsp_result,  res);
    chk({name, ".zero"},    rsp_zero,    z);
    chk({name, ".illegal"}, rsp_illegal, ill);
  endtask

  initial begin
    vecs[0]  = '{4'b0000, 32'd5,         32'd7,         32'd12,        1'b0, 1'b0};
    vecs[1]  = '{4'b0001, 32'd3,         32'd3,         32'd0,         1'b1, 1'b0};
    vecs[2]  = '{4'b0001, 32'd0,         32'd1,         32'hFFFFFFFF,  1'b0, 1'b0};
    vecs[3]  = '{4'b0100, 32'hF0F0F0F0,  32'hFF00FF00,  32'hF000F000,  1'b0, 1'b0};
    vecs[4]  = '{4'b0101, 32'hF0F0F0F0,  32'hFF00FF00,  32'hFFF0FFF0,  1'b0, 1'b0};
    vecs[5]  = '{4'b0110, 32'hF0F0F0F0,  32'hFF00FF00,  32'h0FF00FF0,  1'b0, 1'b0};
    vecs[6]  = '{4'b0111, 32'h12345678,  32'd9,         32'h12345678,  1'b0, 1'b0};
    vecs[7]  = '{4'b1000, 32'd1,         32'h21,        32'd2,         1'b0, 1'b0};
    vecs[8]  = '{4'b1010, 32'h80000000,  32'd4,         32'h08000000,  1'b0, 1'b0};
    vecs[9]  = '{4'b1011, 32'h80000000,  32'd4,         32'hF8000000,  1'b0, 1'b0};
    vecs[10] = '{4'b1100, 32'hFFFFFFFF,  32'd1,         32'd1,         1'b0, 1'b0};
    vecs[11] = '{4'b1101, 32'hFFFFFFFF,  32'd1,         32'd0,         1'b1, 1'b0};
    vecs[12] = '{4'b1111, 32'd1,         32'hDEADBEEF,  32'hDEADBEEF,  1'b0, 1'b0};
    vecs[13] = '{4'b0010, 32'd6,         32'd2,         32'd0,         1'b1, 1'b1};
    vecs[14] = '{4'b1001, 32'd6,         32'd2,         32'd0,         1'b1, 1'b1};
    vecs[15] = '{4'b1110, 32'd6,         32'd2,         32'd0,         1'b1, 1'b1};
    vecs[16] = '{4'b0000, 32'hFFFFFFFF,  32'd1,         32'd0,         1'b1, 1'b0};

    reset = 1'b1; rsp_ready = 1'b0;
    set_req0(1'b1, 4'b0000, 32'd1, 32'd1);
    set_req1(1'b1, 4'b0000, 32'd1, 32'd1);
    #1;
    chk("reset.ready0", req0_ready, 1'b0);
    chk("reset.ready1", req1_ready, 1'b0);
    step(); step();
    chk_rsp("reset", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

    // Opcode table, one op per cycle through requester 0.
    reset = 1'b0; rsp_ready = 1'b1;
    set_req1(1'b0, 4'b0000, 32'h0, 32'h0);
    for (int i = 0; i < 17; i++) begin
      set_req0(1'b1, vecs[i].op, vecs[i].a, vecs[i].b);
      #1;
      chk($sformatf("vec%0d.ready0", i), req0_ready, 1'b1);
      step();
      chk_rsp($sformatf("vec%0d", i), 1'b1, 1'b0, vecs[i].res, vecs[i].zero, vecs[i].ill);
    end

    // Round-robin contention from a fresh reset: req0 wins first.
    reset = 1'b1; step(); reset = 1'b0;
    set_req0(1'b1, 4'b0001, 32'd3, 32'd3);
    set_req1(1'b1, 4'b1011, 32'h80000000, 32'd4);
    for (int i = 0; i < 4; i++) begin
      step();
      if (i % 2 == 0) chk_rsp($sformatf("rr%0d", i), 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
      else            chk_rsp($sformatf("rr%0d", i), 1'b1, 1'b1, 32'hF8000000, 1'b0, 1'b0);
    end

    // Backpressure: held result must not move, even if req1 operands change.
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req1_a = 32'h0000_0000 + i;
      #1;
      chk($sformatf("bp%0d.ready0", i), req0_ready, 1'b0);
      chk($sformatf("bp%0d.ready1", i), req1_ready, 1'b0);
      step();
      chk_rsp($sformatf("bp%0d", i), 1'b1, 1'b1, 32'hF8000000, 1'b0, 1'b0);
    end
    req1_a = 32'h80000000;
    rsp_ready = 1'b1;
    #1;
    chk("bp_release.ready0", req0_ready, 1'b1);
    chk("bp_release.ready1", req1_ready, 1'b0);
    step();
    chk_rsp("bp_release", 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    step();
    chk_rsp("bp_next", 1'b1, 1'b1, 32'hF8000000, 1'b0, 1'b0);

    // Drain with nothing to accept: valid drops, data retained.
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    chk("drain.ready1", req1_ready, 1'b0);
    step();
    chk_rsp("drain", 1'b0, 1'b1, 32'hF8000000, 1'b0, 1'b0);

    // Reset while a result is held under backpressure.
    set_req0(1'b1, 4'b0000, 32'd5, 32'd7);
    rsp_ready = 1'b0;
    step();
    chk_rsp("prersp", 1'b1, 1'b0, 32'd12, 1'b0, 1'b0);
    reset = 1'b1;
    req1_valid = 1'b1;
    #1;
    chk("rst_hold.ready0", req0_ready, 1'b0);
    step();
    chk_rsp("rst_hold", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    reset = 1'b0; rsp_ready = 1'b1;
    #1;
    chk("post_rst.ready0", req0_ready, 1'b1);
    chk("post_rst.ready1", req1_ready, 1'b0);
    step();
    chk_rsp("post_rst", 1'b1, 1'b0, 32'd12, 1'b0, 1'b0);

    // Strict priority instance: req0 always wins while valid.
    reset = 1'b1; step(); reset = 1'b0;
    set_req0(1'b1, 4'b0000, 32'd5, 32'd7);
    set_req1(1'b1, 4'b1111, 32'd0, 32'h55);
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("fp%0d.valid", i), fp_rsp_valid, 1'b1);
      chk($sformatf("fp%0d.id", i), fp_rsp_id, 1'b0);
      chk($sformatf("fp%0d.result", i), fp_rsp_result, 32'd12);
    end
    req0_valid = 1'b0;
    #1;
    chk("fp_req1.ready1", fp_req1_ready, 1'b1);
    step();
    chk("fp_req1.id", fp_rsp_id, 1'b1);
    chk("fp_req1.result", fp_rsp_result, 32'h55);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
